// File: rtl/sseg_scan_mux.sv
// Multiplexed seven-segment scanner: shadowed digit values, leading-zero
// blanking, PWM brightness within each digit slot, registered an/sseg.

// Per-digit hex-to-segment decoder, active-low {g,f,e,d,c,b,a}.
module sseg_digit_dec (
    input  logic [3:0] nib,
    input  logic       blank,
    output logic [6:0] seg
);

    // Standard 0-F glyphs; a blanked digit turns every segment off.
    always_comb begin
        seg = 7'h7F;
        if (!blank) begin
            case (nib)
                4'h0: seg = 7'h40;
                4'h1: seg = 7'h79;
                4'h2: seg = 7'h24;
                4'h3: seg = 7'h30;
                4'h4: seg = 7'h19;
                4'h5: seg = 7'h12;
                4'h6: seg = 7'h02;
                4'h7: seg = 7'h78;
                4'h8: seg = 7'h00;
                4'h9: seg = 7'h10;
                4'hA: seg = 7'h08;
                4'hB: seg = 7'h03;
                4'hC: seg = 7'h46;
                4'hD: seg = 7'h21;
                4'hE: seg = 7'h06;
                default: seg = 7'h0E;
            endcase
        end
    end

endmodule

module sseg_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int CLK_FREQ_HZ = 12000000,
    parameter int REFRESH_HZ  = 1000,
    parameter int BRIGHT_W    = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] hex,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    load,
    input  logic                    blank_lz,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              sseg
);

    // Clocks per PWM phase step; a slot is 2^BRIGHT_W of these.
    localparam int DEN       = REFRESH_HZ * NUM_DIGITS * (2 ** BRIGHT_W);
    localparam int SUB_RAW   = CLK_FREQ_HZ / DEN;
    localparam int SUB_TICKS = (SUB_RAW > 1) ? SUB_RAW : 1;
    localparam int PS_W      = (SUB_TICKS > 1) ? $clog2(SUB_TICKS) : 1;
    localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [PS_W-1:0]                ps;
    logic [BRIGHT_W-1:0]            phase;
    logic [IDX_W-1:0]               idx;
    logic [NUM_DIGITS-1:0][3:0]     sh_hex;
    logic [NUM_DIGITS-1:0]          sh_dp;
    logic [NUM_DIGITS:0]            zr;
    logic [NUM_DIGITS-1:0]          blank;
    logic [NUM_DIGITS-1:0][6:0]     seg_all;
    logic                           sub_tick;
    logic                           slot_end;
    logic                           lit;

    assign sub_tick = (ps == PS_W'(SUB_TICKS - 1));
    assign slot_end = sub_tick && (phase == '1);
    assign lit      = (phase <= brightness);

    // Prescaler: 0..SUB_TICKS-1, sub_tick on terminal count.
    always_ff @(posedge clk) begin
        if (!reset)        ps <= '0;
        else if (sub_tick) ps <= '0;
        else               ps <= ps + 1'b1;
    end

    // PWM phase within the current slot; natural wrap marks the slot end.
    always_ff @(posedge clk) begin
        if (!reset)        phase <= '0;
        else if (sub_tick) phase <= phase + 1'b1;
    end

    // Digit index advances once per slot; a single digit stays at 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx <= '0;
        end else if (slot_end) begin
            if (idx == IDX_W'(NUM_DIGITS - 1)) idx <= '0;
            else                               idx <= idx + 1'b1;
        end
    end

    // Shadow copy so the display only changes when the host asks it to.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sh_hex <= '0;
            sh_dp  <= '0;
        end else if (load) begin
            sh_hex <= hex;
            sh_dp  <= dp_in;
        end
    end

    // Leading-zero run from the top digit down; digit 0 is never blanked.
    always_comb begin
        zr             = '0;
        blank          = '0;
        zr[NUM_DIGITS] = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            zr[k]    = zr[k+1] & (sh_hex[k] == 4'h0);
            blank[k] = blank_lz & zr[k] & (k != 0);
        end
    end

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_dig
            sseg_digit_dec u_dec (
                .nib   (sh_hex[g]),
                .blank (blank[g]),
                .seg   (seg_all[g])
            );
        end
    endgenerate

    // Registered outputs: one-hot-low anode while in the lit part of the slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            an   <= '1;
            sseg <= 8'hFF;
        end else begin
            an   <= lit ? ~(NUM_DIGITS'(1) << idx) : '1;
            sseg <= {~sh_dp[idx], seg_all[idx]};
        end
    end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux at 4 digits, SUB_TICKS=4, 16-clock slots.
module tb_sseg_scan_mux;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] hex;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [1:0]  brightness;
    logic [3:0]  an;
    logic [7:0]  sseg;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int lows[4];
    int multi;

    sseg_scan_mux #(
        .NUM_DIGITS  (4),
        .CLK_FREQ_HZ (64000),
        .REFRESH_HZ  (1000),
        .BRIGHT_W    (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .hex        (hex),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .brightness (brightness),
        .an         (an),
        .sseg       (sseg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One edge, then settle; cyc counts edges since reset release.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int t);
        while (cyc < t) tick();
    endtask

    task automatic count_round();
        for (int i = 0; i < 4; i++) lows[i] = 0;
        multi = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            for (int k = 0; k < 4; k++) if (!an[k]) lows[k]++;
            if ($countones(~an) > 1) multi++;
        end
    endtask

    initial begin
        reset = 1'b0; hex = 16'h0; dp_in = 4'h0; load = 1'b0;
        blank_lz = 1'b0; brightness = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_an", an, 4'hF);
        chk("rst_sseg", sseg, 8'hFF);

        // Release: digit 0 lit with shadow 0, then one digit per 16 clocks.
        reset = 1'b1; cyc = 0;
        run_to(2);
        chk("rel_an", an, 4'hE);
        chk("rel_sseg", sseg, 8'hC0);
        run_to(16);  chk("slot0_end_an", an, 4'hE);
        run_to(17);  chk("scan_d1", an, 4'hD);
        run_to(33);  chk("scan_d2", an, 4'hB);
        run_to(49);  chk("scan_d3", an, 4'h7);
        run_to(65);  chk("scan_wrap", an, 4'hE);

        // Load 12AF with dp on digit 2.
        hex = 16'h12AF; dp_in = 4'b0100; load = 1'b1;
        tick(); load = 1'b0;
        run_to(67);  chk("ld_d0", sseg, 8'h8E); chk("ld_d0_an", an, 4'hE);
        run_to(81);  chk("ld_d1", sseg, 8'h88); chk("ld_d1_an", an, 4'hD);
        run_to(97);  chk("ld_d2", sseg, 8'h24); chk("ld_d2_an", an, 4'hB);
        run_to(113); chk("ld_d3", sseg, 8'hF9); chk("ld_d3_an", an, 4'h7);

        // Leading-zero blanking on 0005.
        run_to(129);
        hex = 16'h0005; dp_in = 4'h0; load = 1'b1; blank_lz = 1'b1;
        tick(); load = 1'b0;
        run_to(131); chk("bl_d0", sseg, 8'h92);
        run_to(145); chk("bl_d1", sseg, 8'hFF); chk("bl_d1_an", an, 4'hD);
        run_to(161); chk("bl_d2", sseg, 8'hFF);
        run_to(177); chk("bl_d3", sseg, 8'hFF); chk("bl_d3_an", an, 4'h7);
        blank_lz = 1'b0;
        tick();      chk("nobl_d3", sseg, 8'hC0);

        // Brightness duty over whole rounds.
        run_to(193);
        brightness = 2'd1;
        count_round();
        for (int k = 0; k < 4; k++) chk($sformatf("bri1_d%0d", k), lows[k], 8);
        chk("bri1_onehot", multi, 0);
        brightness = 2'd0;
        count_round();
        for (int k = 0; k < 4; k++) chk($sformatf("bri0_d%0d", k), lows[k], 4);
        chk("bri0_onehot", multi, 0);

        // hex change without load is invisible.
        brightness = 2'd3; hex = 16'hFFFF;
        tick();      chk("nold_d0", sseg, 8'h92);
        run_to(338); chk("nold_d1", sseg, 8'hC0); chk("nold_d1_an", an, 4'hD);

        // Load on the slot-boundary edge (edge 352 moves to digit 2).
        run_to(351);
        load = 1'b1;
        tick(); load = 1'b0;
        chk("bnd_old_an", an, 4'hD);
        chk("bnd_old_sseg", sseg, 8'hC0);
        tick();
        chk("bnd_new_an", an, 4'hB);
        chk("bnd_new_sseg", sseg, 8'h8E);

        // Reset mid-slot on digit 2, overriding a load.
        run_to(360);
        hex = 16'h1234; load = 1'b1; reset = 1'b0;
        tick();
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_sseg", sseg, 8'hFF);
        reset = 1'b1; load = 1'b0; cyc = 0;
        tick();      chk("rst2_an", an, 4'hE); chk("rst2_sseg", sseg, 8'hC0);
        run_to(17);  chk("rst2_d1_an", an, 4'hD); chk("rst2_d1_sseg", sseg, 8'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
